prga_decrypt: RTL and testbench

PRGA_DECRYPT -- requirements
Module: prga_decrypt

---
 rtl/rc4_pkg.sv | 27 ++
 rtl/prga_decrypt_if.sv | 27 ++
 rtl/char_validator.sv | 13 +
 rtl/prga_decrypt.sv | 147 ++++++++++++++
 tb/tb_prga_decrypt.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions for the PRGA/decrypt stage.
// Contents: default message length, legal-plaintext character bounds and the
// PRGA state encoding.
package rc4_pkg;

    localparam int unsigned MSG_LEN_DEFAULT = 32;

    // Legal plaintext is a space or a lowercase letter.
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WT_I,
        LD_I,
        WT_J,
        LD_J,
        WR_J,
        RD_F,
        WT_F,
        STORE,
        DONE
    } prga_state_t;

endpackage

// File: rtl/prga_decrypt_if.sv
// S RAM port bundle between the PRGA engine (master) and the RAM (slave).
// Signals: s_addr  - RAM address
//          s_wdata - RAM write data
//          s_wren  - RAM write enable
//          s_q     - RAM read data, one cycle after the address is sampled
interface prga_decrypt_if;

    logic [7:0] s_addr;
    logic [7:0] s_wdata;
    logic       s_wren;
    logic [7:0] s_q;

    modport master (
        output s_addr,
        output s_wdata,
        output s_wren,
        input  s_q
    );

    modport slave (
        input  s_addr,
        input  s_wdata,
        input  s_wren,
        output s_q
    );

endinterface

// File: rtl/char_validator.sv
// Combinational legal-character test for decrypted bytes.
// Ports: ch      - candidate plaintext byte
//        legal_c - 1 when ch is a space or in 'a'..'z'
module char_validator
    import rc4_pkg::*;
(
    input  logic [7:0] ch,
    output logic       legal_c
);

    assign legal_c = (ch == CHAR_SPACE) || ((ch >= CHAR_LO) && (ch <= CHAR_HI));

endmodule

// File: rtl/prga_decrypt.sv
// RC4 PRGA stage: walks the KSA-initialised S array, swaps entries, XORs the
// keystream with the ciphertext and grades the plaintext.
// Ports: clk, reset (async, active-low), start,
//        s_ram          - S RAM master port (registered address/data/enable)
//        rom_data_d     - ciphertext bytes
//        decrypted_data - plaintext bytes
//        done, key_good, key_bad - run status
// Build option: define PRGA_EARLY_ABORT_EN to stop at the first illegal byte.
module prga_decrypt
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = MSG_LEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    prga_decrypt_if.master           s_ram,
    input  logic [MSG_LEN-1:0][7:0]  rom_data_d,
    output logic [MSG_LEN-1:0][7:0]  decrypted_data,
    output logic                     done,
    output logic                     key_good,
    output logic                     key_bad
);

    localparam int unsigned    K_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN - 1);

    prga_state_t    state;
    logic [7:0]     i;
    logic [7:0]     j;
    logic [7:0]     si;
    logic [7:0]     sj;
    logic [K_W-1:0] k;
    logic           bad_seen;
    logic [7:0]     plain_c;
    logic           legal_c;

    // Keystream byte arrives on s_q in STORE.
    assign plain_c = s_ram.s_q ^ rom_data_d[k];

    char_validator u_char_validator (
        .ch      (plain_c),
        .legal_c (legal_c)
    );

    // PRGA sequencer. The swap writes S[j]=S[i] in LD_J (S[i] is already held)
    // and S[i]=S[j] in WR_J, so the enable is high for exactly those two states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            i              <= '0;
            j              <= '0;
            si             <= '0;
            sj             <= '0;
            k              <= '0;
            bad_seen       <= 1'b0;
            s_ram.s_addr   <= '0;
            s_ram.s_wdata  <= '0;
            s_ram.s_wren   <= 1'b0;
            decrypted_data <= '0;
            done           <= 1'b0;
            key_good       <= 1'b0;
            key_bad        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                        bad_seen <= 1'b0;
                        key_good <= 1'b0;
                        key_bad  <= 1'b0;
                        state    <= RD_I;
                    end
                end
                RD_I: begin
                    i            <= i + 8'd1;
                    s_ram.s_addr <= i + 8'd1;
                    state        <= WT_I;
                end
                WT_I: state <= LD_I;
                LD_I: begin
                    si           <= s_ram.s_q;
                    j            <= j + s_ram.s_q;
                    s_ram.s_addr <= j + s_ram.s_q;
                    state        <= WT_J;
                end
                WT_J: begin
                    // Address stays at j for the first swap write.
                    s_ram.s_wdata <= si;
                    s_ram.s_wren  <= 1'b1;
                    state         <= LD_J;
                end
                LD_J: begin
                    sj            <= s_ram.s_q;
                    s_ram.s_addr  <= i;
                    s_ram.s_wdata <= s_ram.s_q;
                    s_ram.s_wren  <= 1'b1;
                    state         <= WR_J;
                end
                WR_J: begin
                    s_ram.s_wren <= 1'b0;
                    state        <= RD_F;
                end
                RD_F: begin
                    s_ram.s_addr <= si + sj;
                    state        <= WT_F;
                end
                WT_F: state <= STORE;
                STORE: begin
                    decrypted_data[k] <= plain_c;
                    k                 <= k + K_W'(1);
                    if (!legal_c) begin
                        bad_seen <= 1'b1;
                    end
`ifdef PRGA_EARLY_ABORT_EN
                    if (!legal_c || (k == K_LAST)) begin
                        state <= DONE;
                    end else begin
                        state <= RD_I;
                    end
`else
                    if (k == K_LAST) begin
                        state <= DONE;
                    end else begin
                        state <= RD_I;
                    end
`endif
                end
                DONE: begin
                    // First DONE cycle publishes the verdict; then wait for start low.
                    if (!done) begin
                        done     <= 1'b1;
                        key_good <= !bad_seen;
                        key_bad  <= bad_seen;
                    end else if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prga_decrypt.sv
module tb_prga_decrypt;
    import rc4_pkg::*;

    localparam int unsigned N = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [N-1:0][7:0]  rom_data_d;
    logic [N-1:0][7:0]  decrypted_data;
    logic               done;
    logic               key_good;
    logic               key_bad;

    prga_decrypt_if s_ram ();

    prga_decrypt #(.MSG_LEN(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .s_ram          (s_ram),
        .rom_data_d     (rom_data_d),
        .decrypted_data (decrypted_data),
        .done           (done),
        .key_good       (key_good),
        .key_bad        (key_bad)
    );

    always #5 clk = ~clk;

    // S RAM: registered address, read data one cycle later, old data on collision.
    logic [7:0] mem      [256];
    logic [7:0] init_img [256];
    bit         load_img = 1'b0;

    always @(posedge clk) begin
        if (load_img) begin
            for (int a = 0; a < 256; a++) mem[a] <= init_img[a];
        end else if (s_ram.s_wren) begin
            mem[s_ram.s_addr] <= s_ram.s_wdata;
        end
        s_ram.s_q <= mem[s_ram.s_addr];
    end

    // Reference model state
    logic [7:0] ms      [256];
    logic [7:0] ks      [N];
    logic [7:0] pt      [N];
    logic [7:0] exp_dec [N];
    int         exp_cyc;
    int         last_cyc;
    bit         exp_good;
    bit         exp_bad;
    int         n_checks = 0;
    int         n_fail   = 0;

    logic       lw [16];
    logic [7:0] la [16];
    logic [7:0] ld [16];

    function automatic bit is_legal(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7a);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain RC4 PRGA over a copy of the initial image.
    task automatic model_steps(input int nsteps);
        int mi = 0;
        int mj = 0;
        logic [7:0] t;
        for (int a = 0; a < 256; a++) ms[a] = init_img[a];
        for (int s = 0; s < nsteps; s++) begin
            mi = (mi + 1) % 256;
            mj = (mj + int'(ms[mi])) % 256;
            t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
            ks[s] = ms[(int'(ms[mi]) + int'(ms[mj])) % 256];
        end
    endtask

    task automatic prepare(input int bad_at, input bit fix01);
        int first = -1;
        int n_proc;
        for (int q = 0; q < N; q++) begin
            int r = $urandom_range(26, 0);
            pt[q] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
        end
        if (fix01) begin
            pt[0] = 8'h61;
            pt[1] = 8'h20;
        end
        if (bad_at >= 0) pt[bad_at] = 8'h41;
        model_steps(N);
        for (int q = 0; q < N; q++) rom_data_d[q] = ks[q] ^ pt[q];
        for (int q = 0; q < N; q++) if (!is_legal(pt[q]) && first < 0) first = q;
`ifdef PRGA_EARLY_ABORT_EN
        n_proc = (first >= 0) ? first + 1 : N;
`else
        n_proc = N;
`endif
        for (int q = 0; q < n_proc; q++) exp_dec[q] = pt[q];
        model_steps(n_proc);
        exp_cyc  = 9 * n_proc + 1;
        exp_good = (first < 0);
        exp_bad  = (first >= 0);
    endtask

    task automatic load_ram();
        @(negedge clk) load_img = 1'b1;
        @(negedge clk) load_img = 1'b0;
    endtask

    task automatic random_perm();
        logic [7:0] t;
        for (int a = 0; a < 256; a++) init_img[a] = 8'(a);
        for (int a = 255; a > 0; a--) begin
            int b = $urandom_range(a, 0);
            t = init_img[a]; init_img[a] = init_img[b]; init_img[b] = t;
        end
    endtask

    task automatic run(input bit hold, input int poke_at, input bit do_log);
        int cyc;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        if (do_log) begin lw[0] = s_ram.s_wren; la[0] = s_ram.s_addr; ld[0] = s_ram.s_wdata; end
        while (cyc < 1000 && done !== 1'b1) begin
            @(negedge clk);
            if (!hold) start = (poke_at > 0 && cyc == poke_at);
            @(posedge clk); #1;
            cyc++;
            if (do_log && cyc < 16) begin
                lw[cyc] = s_ram.s_wren; la[cyc] = s_ram.s_addr; ld[cyc] = s_ram.s_wdata;
            end
        end
        last_cyc = cyc;
    endtask

    task automatic check_run(input string tag, input bit hold);
        logic [N*8-1:0] exp_vec;
        int bad = 0;
        for (int q = 0; q < N; q++) exp_vec[q*8 +: 8] = exp_dec[q];
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_cycles"}, last_cyc, exp_cyc);
        chk({tag, "_key_good"}, key_good, exp_good);
        chk({tag, "_key_bad"}, key_bad, exp_bad);
        chk({tag, "_data"}, decrypted_data, exp_vec);
        for (int a = 0; a < 256; a++) if (mem[a] !== ms[a]) bad++;
        chk({tag, "_s_final"}, bad, 0);
        if (hold) begin
            @(posedge clk); #1;
            chk({tag, "_done_held"}, done, 1'b1);
            @(negedge clk) start = 1'b0;
        end
        @(posedge clk); #1;
        chk({tag, "_done_clear"}, done, 1'b0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        rom_data_d = '0;
        for (int q = 0; q < N; q++) exp_dec[q] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", {done, key_good, key_bad, s_ram.s_wren, s_ram.s_addr, s_ram.s_wdata}, '0);
        chk("reset_data", decrypted_data, '0);
        @(negedge clk) reset = 1'b1;

        // Identity S with the known first two bytes
        for (int a = 0; a < 256; a++) init_img[a] = 8'(a);
        load_ram();
        prepare(-1, 1'b1);
        run(1'b1, 0, 1'b0);
        chk("ident_byte0", decrypted_data[0], 8'h61);
        chk("ident_byte1", decrypted_data[1], 8'h20);
        check_run("ident", 1'b1);

        // Illegal 'A' at k=5, single-cycle start pulse
        random_perm();
        load_ram();
        prepare(5, 1'b0);
        run(1'b0, 0, 1'b0);
        check_run("bad5", 1'b0);

        // Reset in the middle of a run
        random_perm();
        load_ram();
        prepare(-1, 1'b0);
        begin
            int cyc;
            @(negedge clk) start = 1'b1;
            @(posedge clk); #1;
            cyc = 0;
            while (cyc < 100) begin @(posedge clk); #1; cyc++; end
            reset = 1'b0;
            start = 1'b0;
            #1;
            chk("midrst_ctl", {done, key_good, key_bad, s_ram.s_wren, s_ram.s_addr, s_ram.s_wdata}, '0);
            chk("midrst_data", decrypted_data, '0);
            for (int q = 0; q < N; q++) exp_dec[q] = 8'h00;
            @(negedge clk) reset = 1'b1;
        end
        load_ram();
        prepare(-1, 1'b0);
        run(1'b1, 0, 1'b0);
        check_run("after_rst", 1'b1);

        // Start re-asserted mid-run must be ignored
        random_perm();
        load_ram();
        prepare(-1, 1'b0);
        run(1'b0, 50, 1'b0);
        check_run("restart", 1'b0);

        // j and index-sum wrap: S[1]=FF, S[FF]=02
        for (int a = 0; a < 256; a++) init_img[a] = 8'(a);
        init_img[1]   = 8'hFF;
        init_img[255] = 8'h02;
        init_img[2]   = 8'h01;
        load_ram();
        prepare(-1, 1'b0);
        run(1'b0, 0, 1'b1);
        begin
            logic [8:0]  wpat;
            logic [23:0] wr_obs;
            for (int c = 0; c < 9; c++) wpat[c] = lw[c];
            chk("wrap_wren_pattern", wpat, 9'b000110000);
            chk("wrap_j_addr", la[3], 8'hFF);
            wr_obs = (la[4] == 8'hFF) ? {ld[4], ld[5], la[5]} : {ld[5], ld[4], la[4]};
            chk("wrap_swap_writes", wr_obs, {8'hFF, 8'h02, 8'h01});
            chk("wrap_sum_addr", la[7], 8'h01);
            chk("wrap_byte0", decrypted_data[0], 8'h02 ^ rom_data_d[0]);
        end
        check_run("wrap", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
